// File: rtl/pulpemu_uart_pkg.sv
// Shared types and constants for the PULP-emulation UART receiver.
package pulpemu_uart_pkg;

  localparam int          DATA_W  = 8;
  localparam logic [15:0] MIN_DIV = 16'd3;

`ifdef PULPEMU_UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

endpackage

// File: rtl/pulpemu_uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head is visible on data_o whenever not empty.
// Push on full succeeds only when a pop happens in the same cycle.
module pulpemu_uart_rx_fifo
  import pulpemu_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              do_push, do_pop;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pulpemu_uart_rx.sv
// 8N1 UART receiver with sticky frame/overflow flags feeding a FWFT FIFO.
// Define PULPEMU_UART_RX_PARITY_EN to add an even-parity bit and parity_err_o.
module pulpemu_uart_rx
  import pulpemu_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] div_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        clr_i,
  output logic        frame_err_o,
  output logic        overflow_o,
`ifdef PULPEMU_UART_RX_PARITY_EN
  output logic        parity_err_o,
`endif
  output logic        busy_o
);

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]  warm_q;
  state_e      state_q;
  logic [15:0] cnt_q, div_q, div_eff;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        push_q, frame_err_q, overflow_q, overflow_d;
  logic        fifo_full, fifo_empty, pop, fall;
`ifdef PULPEMU_UART_RX_PARITY_EN
  logic        parity_err_q, par_ok_q;
`endif

  assign div_eff = (div_i < MIN_DIV) ? MIN_DIV : div_i;
  assign fall    = rx_prev_q & ~rx_s2_q;

  // rx_prev_q only holds real line samples once the synchronizer has flushed its
  // reset value, so a line held low across reset never looks like a falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b0;
      warm_q    <= 2'b00;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= warm_q[1] & rx_s2_q;
      warm_q    <= {warm_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= MIN_DIV;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PULPEMU_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_ok_q     <= 1'b1;
`endif
    end else begin
      push_q <= 1'b0;
      if (clr_i) frame_err_q <= 1'b0;
`ifdef PULPEMU_UART_RX_PARITY_EN
      if (clr_i) parity_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: if (fall) begin
          state_q <= ST_START;
          cnt_q   <= div_eff >> 1;
          div_q   <= div_eff;
        end
        ST_START: if (cnt_q == '0) begin
          if (!rx_s2_q) begin
            state_q <= ST_DATA;
            cnt_q   <= div_q;
            bit_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end else cnt_q <= cnt_q - 16'd1;
        ST_DATA: if (cnt_q == '0) begin
          shift_q <= {rx_s2_q, shift_q[7:1]};
          cnt_q   <= div_q;
          bit_q   <= bit_q + 3'd1;
`ifdef PULPEMU_UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_q <= ST_PARITY;
`else
          if (bit_q == 3'd7) state_q <= ST_STOP;
`endif
        end else cnt_q <= cnt_q - 16'd1;
`ifdef PULPEMU_UART_RX_PARITY_EN
        ST_PARITY: if (cnt_q == '0) begin
          cnt_q    <= div_q;
          state_q  <= ST_STOP;
          par_ok_q <= ~(^shift_q ^ rx_s2_q);
          if (^shift_q ^ rx_s2_q) parity_err_q <= 1'b1;
        end else cnt_q <= cnt_q - 16'd1;
`endif
        ST_STOP: if (cnt_q == '0) begin
          state_q <= ST_IDLE;
`ifdef PULPEMU_UART_RX_PARITY_EN
          if (rx_s2_q) push_q <= par_ok_q;
`else
          if (rx_s2_q) push_q <= 1'b1;
`endif
          else frame_err_q <= 1'b1;
        end else cnt_q <= cnt_q - 16'd1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop        = valid_o & ready_i;
  assign overflow_d = (push_q & fifo_full & ~pop) | (overflow_q & ~clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  pulpemu_uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o     = ~fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef PULPEMU_UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_pulpemu_uart_rx.sv
// Scoreboard bench for pulpemu_uart_rx: serial frames in, expected bytes queued, monitor pops on handshake.
module tb_pulpemu_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i, rx_i, clr_i;
  logic [15:0] div_i;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, overflow_o, busy_o;
`ifdef PULPEMU_UART_RX_PARITY_EN
  logic        parity_err_o;
`endif

  logic rnd_mode = 1'b0, rnd_rdy = 1'b1, rdy_man = 1'b1, scramble = 1'b0;
  assign ready_i = rnd_mode ? rnd_rdy : rdy_man;

  int         tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk_i = ~clk_i;

  pulpemu_uart_rx #(.FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .div_i       (div_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .clr_i       (clr_i),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
`ifdef PULPEMU_UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference acceptance rule: a byte is delivered iff the stop bit is high and, with parity, the bit count is even.
  function automatic bit frame_ok(input logic [7:0] b, input logic stop_b, input logic par_b);
`ifdef PULPEMU_UART_RX_PARITY_EN
    return stop_b && (par_b == ^b);
`else
    return stop_b;
`endif
  endfunction

  always begin
    @(posedge clk_i); #1;
    rnd_rdy = ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got %02h, expected no byte", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_byte", {24'd0, data_o}, {24'd0, mon_exp});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_bit(input logic v, input int n);
    rx_i = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b, input bit expect_it);
    int per;
    per = (div_i < 16'd3) ? 4 : int'(div_i) + 1;
    if (expect_it) exp_q.push_back(b);
    send_bit(1'b0, per);
    if (scramble) div_i = 16'($urandom_range(0, 40));
    for (int i = 0; i < 8; i++) send_bit(b[i], per);
`ifdef PULPEMU_UART_RX_PARITY_EN
    send_bit(par_b, per);
`endif
    send_bit(stop_b, per);
    send_bit(1'b1, 2 * per);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 3000 && exp_q.size() != 0; k++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       st, pb;
    bit         any_stop_bad, any_par_bad;
    int         k;

    rst_i = 1'b1; rx_i = 1'b1; clr_i = 1'b0; div_i = 16'd15;
    tick(3);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overflow", overflow_o, 0);
`ifdef PULPEMU_UART_RX_PARITY_EN
    check("rst_parity_err", parity_err_o, 0);
`endif
    rst_i = 1'b0;
    tick(5);

    // Single clean frame
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
    drain("a5_drain");
    check("a5_frame_err", frame_err_o, 0);
    check("a5_overflow", overflow_o, 0);

    // Short low glitch must not start a frame
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    for (k = 0; k < 10 && busy_o; k++) tick(1);
    check("glitch_busy", busy_o, 0);
    tick(40);
    check("glitch_valid", valid_o, 0);
    check("glitch_flags", {frame_err_o, overflow_o}, 0);

    // Framing error, clear, then recovery
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    check("ferr_set", frame_err_o, 1);
    check("ferr_valid", valid_o, 0);
    pulse_clr();
    check("ferr_clr", frame_err_o, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    drain("3c_drain");
    check("3c_frame_err", frame_err_o, 0);

    // Overflow: 5 bytes into a 4-deep FIFO with the consumer stalled
    rdy_man = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, ^b, i <= 4);
    end
    check("ovf_set", overflow_o, 1);
    check("ovf_valid", valid_o, 1);
    check("ovf_head", data_o, 8'h01);
    rdy_man = 1'b1;
    drain("ovf_drain");
    tick(5);
    check("ovf_empty", valid_o, 0);
    pulse_clr();
    check("ovf_clr", overflow_o, 0);

    // Reset in the middle of a 0xFF frame
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    rst_i = 1'b1;
    tick(2);
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", valid_o, 0);
    rst_i = 1'b0;
    tick(120);
    check("midrst_novalid", valid_o, 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1);
    drain("5a_drain");

`ifdef PULPEMU_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("par_err_set", parity_err_o, 1);
    check("par_err_valid", valid_o, 0);
    pulse_clr();
    check("par_err_clr", parity_err_o, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    drain("par_ok_drain");
`endif

    // Randomized frames: random divisor (including clamped values), random stop/parity errors,
    // random consumer stalls, and div_i disturbed mid-frame.
    rnd_mode = 1'b1;
    any_stop_bad = 1'b0;
    any_par_bad  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      scramble = 1'b0;
      div_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(5, 24));
      tick(3);
      scramble = 1'b1;
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) != 0);
      pb = ($urandom_range(0, 4) != 0) ? ^b : ~^b;
      if (!st) any_stop_bad = 1'b1;
`ifdef PULPEMU_UART_RX_PARITY_EN
      if (pb != ^b) any_par_bad = 1'b1;
`endif
      send_frame(b, st, pb, frame_ok(b, st, pb));
      scramble = 1'b0;
      div_i = 16'd15;
    end
    drain("rnd_drain");
    check("rnd_overflow", overflow_o, 0);
    check("rnd_frame_err", frame_err_o, any_stop_bad);
`ifdef PULPEMU_UART_RX_PARITY_EN
    check("rnd_parity_err", parity_err_o, any_par_bad);
`endif
    rnd_mode = 1'b0;
    tick(20);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
